// File: rtl/fifo_mem_mc.sv
// fifo_mem_mc: multi-channel FIFO storage with write-side pointer logic.
//
// CH independent FIFO regions share one register array, each 2**A_SIZE words deep.
// The write domain owns, per channel: binary/Gray write pointers, a two-flop read-pointer
// synchroniser, full, almost-full and a sticky overflow flag.
//
// Ports:
//   w_clk, w_rstn  write clock, asynchronous active-low reset
//   w_inc          write request
//   w_ch           channel selected for the write
//   w_data         write data
//   w_ovf_clr      clears every overflow bit (a same-cycle set wins)
//   r_gptr         per-channel Gray read pointers from the read domain (unsynchronised)
//   r_ch, r_addr   combinational read port select
//   r_data         combinational read data
//   w_full         per-channel full, registered
//   w_afull        per-channel almost-full, registered
//   w_gptr         per-channel Gray write pointers, registered, packed like r_gptr
//   w_ovf          per-channel sticky overflow, registered
module fifo_mem_mc #(
    parameter int unsigned D_SIZE   = 8,
    parameter int unsigned A_SIZE   = 3,
    parameter int unsigned CH       = 4,
    parameter int unsigned AF_LEVEL = 6
) (
    input  logic                       w_clk,
    input  logic                       w_rstn,
    input  logic                       w_inc,
    input  logic [$clog2(CH)-1:0]      w_ch,
    input  logic [D_SIZE-1:0]          w_data,
    input  logic                       w_ovf_clr,
    input  logic [CH*(A_SIZE+1)-1:0]   r_gptr,
    input  logic [$clog2(CH)-1:0]      r_ch,
    input  logic [A_SIZE-1:0]          r_addr,
    output logic [D_SIZE-1:0]          r_data,
    output logic [CH-1:0]              w_full,
    output logic [CH-1:0]              w_afull,
    output logic [CH*(A_SIZE+1)-1:0]   w_gptr,
    output logic [CH-1:0]              w_ovf
);

    localparam int unsigned CH_W    = $clog2(CH);
    localparam int unsigned F_DEPTH = 2 ** A_SIZE;
    localparam int unsigned PW      = A_SIZE + 1;
    localparam int unsigned WORDS   = CH * F_DEPTH;

    localparam logic [PW-1:0] AfLevel = PW'(AF_LEVEL);

    typedef logic [PW-1:0] ptr_t;

    ptr_t [CH-1:0] wbin_q, wbin_d;
    ptr_t [CH-1:0] wgray_q, wgray_d;
    ptr_t [CH-1:0] rq1_q, rq2_q, rq2_d;
    ptr_t [CH-1:0] rq_bin;

    logic [CH-1:0] full_q, full_d;
    logic [CH-1:0] afull_q, afull_d;
    logic [CH-1:0] ovf_q, ovf_d;

    logic [D_SIZE-1:0] mem_q [WORDS];
    logic [D_SIZE-1:0] mem_d [WORDS];

    logic                   accept;
    logic [CH_W+A_SIZE-1:0] waddr;

    assign accept = w_inc && !full_q[w_ch];
    assign waddr  = {w_ch, wbin_q[w_ch][A_SIZE-1:0]};

    // Flags are registered on the same edge that loads sync2, so they are computed from the
    // value sync2 is about to take. This gives the two-edge release latency.
    assign rq2_d = rq1_q;

    always_comb begin
        wbin_d  = wbin_q;
        wgray_d = wgray_q;
        rq_bin  = '0;
        full_d  = '0;
        afull_d = '0;
        for (int c = 0; c < CH; c++) begin
            if (accept && (w_ch == CH_W'(c))) begin
                wbin_d[c] = wbin_q[c] + PW'(1);
            end
            wgray_d[c] = wbin_d[c] ^ (wbin_d[c] >> 1);
            for (int i = 0; i < PW; i++) begin
                rq_bin[c][i] = ^(rq2_d[c] >> i);
            end
            // Full when the write pointer is one lap ahead: top two Gray bits inverted.
            full_d[c]  = (wgray_d[c] == {~rq2_d[c][A_SIZE -: 2], rq2_d[c][A_SIZE-2:0]});
            afull_d[c] = ((wbin_d[c] - rq_bin[c]) >= AfLevel);
        end
    end

    always_comb begin
        ovf_d = w_ovf_clr ? '0 : ovf_q;
        if (w_inc && full_q[w_ch]) begin
            ovf_d[w_ch] = 1'b1;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (accept) begin
            mem_d[waddr] = w_data;
        end
    end

    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            rq1_q   <= '0;
            rq2_q   <= '0;
            full_q  <= '0;
            afull_q <= '0;
            ovf_q   <= '0;
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            rq1_q   <= r_gptr;
            rq2_q   <= rq2_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
            mem_q   <= mem_d;
        end
    end

    assign r_data  = mem_q[{r_ch, r_addr}];
    assign w_full  = full_q;
    assign w_afull = afull_q;
    assign w_gptr  = wgray_q;
    assign w_ovf   = ovf_q;

    // rq2_q is the architectural sync2 stage; flags already see its next value.
    logic unused_rq2;
    assign unused_rq2 = ^rq2_q;

endmodule

// File: tb/tb_fifo_mem_mc.sv
// tb_fifo_mem_mc: directed bench for fifo_mem_mc with hand-computed expectations.
module tb_fifo_mem_mc;

    logic        w_clk;
    logic        w_rstn;
    logic        w_inc;
    logic [1:0]  w_ch;
    logic [7:0]  w_data;
    logic        w_ovf_clr;
    logic [15:0] r_gptr;
    logic [1:0]  r_ch;
    logic [2:0]  r_addr;
    logic [7:0]  r_data;
    logic [3:0]  w_full;
    logic [3:0]  w_afull;
    logic [15:0] w_gptr;
    logic [3:0]  w_ovf;

    int total = 0;
    int bad   = 0;

    fifo_mem_mc #(
        .D_SIZE   (8),
        .A_SIZE   (3),
        .CH       (4),
        .AF_LEVEL (6)
    ) dut (
        .w_clk     (w_clk),
        .w_rstn    (w_rstn),
        .w_inc     (w_inc),
        .w_ch      (w_ch),
        .w_data    (w_data),
        .w_ovf_clr (w_ovf_clr),
        .r_gptr    (r_gptr),
        .r_ch      (r_ch),
        .r_addr    (r_addr),
        .r_data    (r_data),
        .w_full    (w_full),
        .w_afull   (w_afull),
        .w_gptr    (w_gptr),
        .w_ovf     (w_ovf)
    );

    initial begin
        w_clk = 1'b0;
        forever #5 w_clk = ~w_clk;
    end

    task automatic tick;
        @(posedge w_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] gray(input int b);
        logic [3:0] x;
        x = 4'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic rd(input logic [1:0] ch, input logic [2:0] addr, input logic [7:0] exp,
                      input string tag);
        r_ch   = ch;
        r_addr = addr;
        #1;
        chk(tag, r_data, exp);
    endtask

    initial begin
        w_rstn    = 1'b0;
        w_inc     = 1'b0;
        w_ch      = '0;
        w_data    = '0;
        w_ovf_clr = 1'b0;
        r_gptr    = '0;
        r_ch      = '0;
        r_addr    = '0;
        tick;
        tick;
        w_rstn = 1'b1;

        // Reset mid-stream: two writes to channel 1, reset dropped during the second.
        w_inc  = 1'b1;
        w_ch   = 2'd1;
        w_data = 8'h11;
        tick;
        chk("pre_rst_gptr1", w_gptr[7:4], 4'b0001);
        w_data = 8'h22;
        #3;
        w_rstn = 1'b0;
        #1;
        chk("rst_full", w_full, 4'h0);
        chk("rst_afull", w_afull, 4'h0);
        chk("rst_ovf", w_ovf, 4'h0);
        chk("rst_gptr", w_gptr, 16'h0000);
        tick;
        for (int a = 0; a < 32; a++) begin
            rd(2'(a / 8), 3'(a % 8), 8'h00, $sformatf("rst_mem_%0d", a));
        end
        w_inc  = 1'b0;
        w_rstn = 1'b1;
        tick;
        chk("rst_gptr_after", w_gptr, 16'h0000);

        // Fill channel 2.
        for (int i = 0; i < 8; i++) begin
            w_inc  = 1'b1;
            w_ch   = 2'd2;
            w_data = 8'(8'hA0 + i);
            tick;
            chk($sformatf("fill_afull_%0d", i), w_afull[2], (i >= 5) ? 1 : 0);
            chk($sformatf("fill_full_%0d", i), w_full[2], (i == 7) ? 1 : 0);
        end
        w_inc = 1'b0;
        chk("fill_gptr", w_gptr, 16'h0C00);
        rd(2'd2, 3'd5, 8'hA5, "fill_rd_c2a5");
        rd(2'd0, 3'd5, 8'h00, "fill_rd_c0a5");
        rd(2'd1, 3'd5, 8'h00, "fill_rd_c1a5");
        rd(2'd3, 3'd5, 8'h00, "fill_rd_c3a5");

        // Overflow on full channel 2.
        w_inc  = 1'b1;
        w_ch   = 2'd2;
        w_data = 8'hFF;
        tick;
        w_inc = 1'b0;
        chk("ovf_set", w_ovf, 4'b0100);
        chk("ovf_gptr", w_gptr[11:8], 4'b1100);
        chk("ovf_full", w_full[2], 1);
        rd(2'd2, 3'd0, 8'hA0, "ovf_rd_c2a0");
        w_ovf_clr = 1'b1;
        tick;
        w_ovf_clr = 1'b0;
        chk("ovf_clr", w_ovf, 4'b0000);

        // Release one entry of channel 2.
        r_gptr[11:8] = 4'b0001;
        tick;
        chk("rel_full_k", w_full[2], 1);
        tick;
        chk("rel_full_k1", w_full[2], 0);
        chk("rel_afull", w_afull[2], 1);
        w_inc  = 1'b1;
        w_ch   = 2'd2;
        w_data = 8'hB0;
        tick;
        w_inc = 1'b0;
        chk("rel_refull", w_full[2], 1);
        chk("rel_gptr", w_gptr[11:8], 4'b1101);
        rd(2'd2, 3'd0, 8'hB0, "rel_rd_c2a0");

        // Wrap channel 0 with the read pointer trailing by three writes.
        for (int n = 0; n < 20; n++) begin
            r_gptr[3:0] = (n >= 3) ? gray(n - 3) : 4'b0000;
            w_inc  = 1'b1;
            w_ch   = 2'd0;
            w_data = 8'(8'h30 + n);
            tick;
            chk($sformatf("wrap_full_%0d", n), w_full[0], 0);
            chk($sformatf("wrap_afull_%0d", n), w_afull[0], 0);
            chk($sformatf("wrap_gptr_%0d", n), w_gptr[3:0], gray((n + 1) % 16));
            rd(2'd0, 3'(n % 8), 8'(8'h30 + n), $sformatf("wrap_rd_%0d", n));
            if (n == 14) chk("wrap_g15", w_gptr[3:0], 4'b1000);
            if (n == 15) chk("wrap_g0", w_gptr[3:0], 4'b0000);
        end
        w_inc = 1'b0;

        // Interleave channels 1 and 3; channel 3 gets read slack so only channel 1 fills.
        r_gptr[15:12] = 4'b0110;
        tick;
        tick;
        for (int k = 0; k < 18; k++) begin
            w_inc  = 1'b1;
            w_ch   = (k % 2 == 0) ? 2'd1 : 2'd3;
            w_data = (k % 2 == 0) ? 8'(8'h50 + k / 2) : 8'(8'h70 + k / 2);
            tick;
            if (k == 14) chk("il_full1", w_full[1], 1);
            if (k == 16) chk("il_ovf1", w_ovf, 4'b0010);
        end
        w_inc = 1'b0;
        chk("il_ovf_end", w_ovf, 4'b0010);
        chk("il_full_end", w_full, 4'b0110);
        chk("il_afull3", w_afull[3], 0);
        chk("il_gptr", w_gptr, {4'b1101, 4'b1101, 4'b1100, 4'b0110});
        rd(2'd1, 3'd0, 8'h50, "il_rd_c1a0");
        rd(2'd1, 3'd7, 8'h57, "il_rd_c1a7");
        rd(2'd3, 3'd1, 8'h71, "il_rd_c3a1");
        rd(2'd3, 3'd0, 8'h78, "il_rd_c3a0");
        rd(2'd2, 3'd0, 8'hB0, "il_rd_c2a0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_mem_mc.md
# fifo_mem_mc

Multi-channel successor to the single-channel async-FIFO storage block. It holds `CH` independent FIFO regions in one shared register array, each region `2**A_SIZE` entries deep. The block owns the write side of every channel: binary and Gray write pointers, read-pointer synchronisation, full, almost-full and sticky overflow. Reads are a combinational port addressed by the read domain's own pointer logic.

## Interface
- `D_SIZE`, 8, data width
- `A_SIZE`, 3, per-channel address width (≥2); per-channel depth `F_DEPTH = 2**A_SIZE`
- `CH`, 4, channel count (power of two, ≥2); `CH_W = log2(CH)`
- `AF_LEVEL`, 6, almost-full threshold in entries (1..`F_DEPTH`)

- `w_clk`  in  1  write-domain clock
- `w_rstn`  in  1  reset, asynchronous, active-low
- `w_inc`  in  1  write request
- `w_ch`  in  `CH_W`  channel selected for the write
- `w_data`  in  `D_SIZE`  write data
- `w_ovf_clr`  in  1  clears all `w_ovf` bits
- `r_gptr`  in  `CH*(A_SIZE+1)`  per-channel Gray read pointers, read domain, unsynchronised; channel c occupies bits `[c*(A_SIZE+1) +: A_SIZE+1]`
- `r_ch`  in  `CH_W`  read channel select
- `r_addr`  in  `A_SIZE`  read address within the channel
- `r_data`  out  `D_SIZE`  read data, combinational
- `w_full`  out  `CH`  per-channel full, registered
- `w_afull`  out  `CH`  per-channel almost-full, registered
- `w_gptr`  out  `CH*(A_SIZE+1)`  per-channel Gray write pointers, registered, same packing as `r_gptr`
- `w_ovf`  out  `CH`  sticky overflow, registered

## Operation
- Storage is `CH*F_DEPTH` words. Channel c, address a maps to word `{c, a}`.
- Write accept: `w_inc && !w_full[w_ch]`. On accept:
  - store `w_data` at `{w_ch, wbin[w_ch][A_SIZE-1:0]}`;
  - `wbin[w_ch]` increments, wrapping modulo `2**(A_SIZE+1)`;
  - `w_gptr[w_ch]` takes `next ^ (next >> 1)`.
- Other channels' pointers and memory are untouched.
- Synchronisation: each `r_gptr` lane passes through two `w_clk` flops, giving `rq2[c]`. `rq_bin[c]` is the Gray-to-binary conversion of `rq2[c]`.
- Full, registered each cycle per channel: `full_next[c] = (wgray_next[c] == {~rq2[c][A_SIZE:A_SIZE-1], rq2[c][A_SIZE-2:0]})`. `wgray_next` is the post-accept pointer, or the current pointer if channel c has no accept this cycle.
- Almost-full, registered: `afull_next[c] = ((wbin_next[c] - rq_bin[c]) mod 2**(A_SIZE+1)) >= AF_LEVEL`.
- Overflow:
  - `w_inc && w_full[w_ch]` sets `w_ovf[w_ch]`. Memory and pointers are unchanged.
  - `w_ovf_clr` clears all bits. If set and clear happen in the same cycle, set wins for that channel.
- Reset (asynchronous, any time, including mid-write):
  - all pointers, sync flops, `w_full`, `w_afull` and `w_ovf` go to 0;
  - all memory words go to 0, so `r_data` = 0 for every address;
  - an in-flight write is discarded.

## Timing
- Write: data is visible on `r_data` (matching `r_ch`/`r_addr`) immediately after the accepting edge. `w_gptr` updates on that same edge.
- `w_full` / `w_afull` assert on the accepting edge that reaches the threshold, with zero cycles of slack. No write is ever accepted into a full channel.
- Read-pointer release latency: `r_gptr` changes before edge k, sync1 captures at edge k, sync2 at k+1, and `w_full` / `w_afull` deassert at edge k+1. The combinational path from sync2 is registered on the same edge, so flags respond two edges after the change.
- Simultaneous write accept and a `rq2` change in the same cycle: flags use the post-accept write pointer and the current `rq2`.
- `r_data` has no latency. The read domain guarantees it only addresses entries that are valid and not being written.

## Test plan
- **Reset:** assert `w_rstn` = 0 mid-stream, with `r_gptr` = 0.
  - Expect `w_full` = 0, `w_afull` = 0, `w_ovf` = 0, `w_gptr` = 0.
  - Expect `r_data` = 0x00 for all 32 `{r_ch, r_addr}` values.
- **Fill channel 2:** 8 writes 0xA0..0xA7, `r_gptr` = 0.
  - `w_afull[2]` rises on the 6th accepting edge; `w_full[2]` rises on the 8th.
  - `w_gptr` lane 2 = 4'b1100.
  - `r_ch` = 2, `r_addr` = 5 reads 0xA5. Channels 0, 1, 3 still read 0x00.
- **Overflow:** 9th write 0xFF to channel 2 while full.
  - Address 0 of channel 2 still holds 0xA0; pointer unchanged; `w_ovf` = 4'b0100.
  - `w_ovf_clr` pulse clears it to 0.
- **Release:** set lane 2 of `r_gptr` to 4'b0001.
  - `w_full[2]` falls exactly 2 edges later.
  - Writing 0xB0 then lands at channel 2, address 0; `w_full[2]` re-rises on that edge.
- **Wrap:** 20 writes on channel 0 with `r_gptr` lane 0 tracking the write pointer 3 cycles late.
  - `w_full[0]` never asserts.
  - The pointer wraps binary 15→0 (Gray 4'b1000→4'b0000).
  - Word n lands at address n mod 8.
- **Interleave:** alternate writes to channels 1 and 3 every cycle, with `w_inc` held high through a full condition on channel 1.
  - Only channel 1 stalls and sets `w_ovf[1]`.
  - Channel 3 data and pointer are unaffected.
